// File: rtl/sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package sub_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_sub_borrow_if.sv
// Start/busy/done handshake and operand/result bus of the serial subtractor.
interface serial_sub_borrow_if
  import sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] da;
  logic [WIDTH-1:0] db;
  logic             dbin;
  logic [WIDTH-1:0] ds;
  logic             dborrow;
  logic             busy;
  logic             done;

  modport master (
    output start, da, db, dbin,
    input  ds, dborrow, busy, done
  );

  modport slave (
    input  start, da, db, dbin,
    output ds, dborrow, busy, done
  );

endinterface

// File: rtl/full_sub_bit.sv
// Combinational 1-bit full subtractor: d = a - b - bin, bout on underflow.
module full_sub_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_sub_borrow.sv
// Bit-serial subtractor ds = da - db - dbin, LSB first, one bit per clock,
// with start/busy/done handshake and registered, held result.
module serial_sub_borrow
  import sub_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input logic                clk,
  input logic                rst,
  serial_sub_borrow_if.slave bus
);

  state_t           state, state_next;
  logic [WIDTH-1:0] ra, rb, rr, ds_q;
  logic             br, dborrow_q;
  logic [CW-1:0]    cnt;
  logic             d, bout, last;
  logic             busy, done;

  full_sub_bit u_bit (
    .a    (ra[0]),
    .b    (rb[0]),
    .bin  (br),
    .d    (d),
    .bout (bout)
  );

  assign last = (cnt == CW'(WIDTH - 1));

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE:  if (bus.start) state_next = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every register, including the shift registers, is reset so nothing starts as X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra        <= '0;
      rb        <= '0;
      rr        <= '0;
      br        <= 1'b0;
      cnt       <= '0;
      ds_q      <= '0;
      dborrow_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (bus.start) begin
          ra  <= bus.da;
          rb  <= bus.db;
          br  <= bus.dbin;
          rr  <= '0;
          cnt <= '0;
        end
        SHIFT: begin
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          br  <= bout;
          rr  <= {d, rr[WIDTH-1:1]};
          cnt <= cnt + CW'(1);
          // The last bit is folded in here so the result lands on the same edge.
          if (last) begin
            ds_q      <= {d, rr[WIDTH-1:1]};
            dborrow_q <= bout;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ds      = ds_q;
  assign bus.dborrow = dborrow_q;
  assign bus.busy    = busy;
  assign bus.done    = done;

endmodule

// File: tb/tb_serial_sub_borrow.sv
// Self-checking bench for serial_sub_borrow at WIDTH=4 and WIDTH=8.
module tb_serial_sub_borrow;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_sub_borrow_if #(.WIDTH(4)) bus4 ();
  serial_sub_borrow_if #(.WIDTH(8)) bus8 ();

  serial_sub_borrow #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  serial_sub_borrow #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));

  int pass_cnt  = 0;
  int total_cnt = 0;
  int both_cnt  = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] ds;
    logic       bw;
  } vec_t;

  vec_t vecs[6];

  always @(negedge clk) begin
    if ((bus4.busy && bus4.done) || (bus8.busy && bus8.done)) both_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic set_in(input bit sel, input logic s, input logic [15:0] a,
                        input logic [15:0] b, input logic bin);
    if (sel) begin
      bus8.start = s; bus8.da = a[7:0]; bus8.db = b[7:0]; bus8.dbin = bin;
    end else begin
      bus4.start = s; bus4.da = a[3:0]; bus4.db = b[3:0]; bus4.dbin = bin;
    end
  endtask

  task automatic sample(input bit sel, output logic [15:0] ds, output logic bw,
                        output logic busy, output logic done);
    if (sel) begin
      ds = {8'd0, bus8.ds}; bw = bus8.dborrow; busy = bus8.busy; done = bus8.done;
    end else begin
      ds = {12'd0, bus4.ds}; bw = bus4.dborrow; busy = bus4.busy; done = bus4.done;
    end
  endtask

  // Called just after a falling edge; returns just after a falling edge, idle.
  task automatic run_op(input bit sel, input logic [15:0] a, input logic [15:0] b,
                        input logic bin, output logic [15:0] ds, output logic bw,
                        output int done_at, output int busy_n, output int done_n);
    int w;
    logic [15:0] s_ds;
    logic s_bw, s_busy, s_done;
    w = sel ? 8 : 4;
    ds = '0; bw = 1'b0; done_at = 0; busy_n = 0; done_n = 0;
    set_in(sel, 1'b1, a, b, bin);
    @(posedge clk);
    for (int n = 1; n <= w + 3; n++) begin
      @(negedge clk);
      if (n == 1) set_in(sel, 1'b0, a, b, bin);
      sample(sel, s_ds, s_bw, s_busy, s_done);
      if (s_busy) busy_n++;
      if (s_done) begin
        done_n++;
        done_at = n;
        ds = s_ds;
        bw = s_bw;
      end
    end
  endtask

  initial begin
    logic [15:0] r_ds, s_ds;
    logic r_bw, s_bw, s_busy, s_done;
    int done_at, busy_n, done_n, first_at, second_at;
    logic [15:0] first_ds, second_ds, hold_ds;

    vecs[0] = '{a: 4'd9,  b: 4'd3,  bin: 1'b0, ds: 4'b0110, bw: 1'b0};
    vecs[1] = '{a: 4'd3,  b: 4'd9,  bin: 1'b0, ds: 4'b1010, bw: 1'b1};
    vecs[2] = '{a: 4'd0,  b: 4'd0,  bin: 1'b1, ds: 4'b1111, bw: 1'b1};
    vecs[3] = '{a: 4'd15, b: 4'd15, bin: 1'b1, ds: 4'b1111, bw: 1'b1};
    vecs[4] = '{a: 4'd15, b: 4'd0,  bin: 1'b0, ds: 4'b1111, bw: 1'b0};
    vecs[5] = '{a: 4'd7,  b: 4'd7,  bin: 1'b0, ds: 4'b0000, bw: 1'b0};

    set_in(1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
    set_in(1'b1, 1'b0, 16'd0, 16'd0, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_ds",      {28'd0, bus4.ds}, 32'd0);
    check("reset_dborrow", {31'd0, bus4.dborrow}, 32'd0);
    check("reset_busy",    {31'd0, bus4.busy}, 32'd0);
    check("reset_done",    {31'd0, bus4.done}, 32'd0);
    check("reset_ds8",     {24'd0, bus8.ds}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed table at WIDTH=4.
    for (int i = 0; i < 6; i++) begin
      run_op(1'b0, {12'd0, vecs[i].a}, {12'd0, vecs[i].b}, vecs[i].bin,
             r_ds, r_bw, done_at, busy_n, done_n);
      check($sformatf("vec%0d_ds", i), {16'd0, r_ds}, {28'd0, vecs[i].ds});
      check($sformatf("vec%0d_borrow", i), {31'd0, r_bw}, {31'd0, vecs[i].bw});
      check($sformatf("vec%0d_done_at", i), done_at, 32'd5);
      check($sformatf("vec%0d_busy_cycles", i), busy_n, 32'd4);
      check($sformatf("vec%0d_done_pulses", i), done_n, 32'd1);
      check($sformatf("vec%0d_hold_ds", i), {28'd0, bus4.ds}, {28'd0, vecs[i].ds});
    end

    // start held high, operands changing mid-operation.
    first_at = 0; second_at = 0; done_n = 0;
    first_ds = '0; second_ds = '0; hold_ds = '0;
    set_in(1'b0, 1'b1, 16'd9, 16'd3, 1'b0);
    @(posedge clk);
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 1)  set_in(1'b0, 1'b1, 16'd1, 16'd2, 1'b1);
      if (n == 3)  set_in(1'b0, 1'b1, 16'd7, 16'd2, 1'b0);
      if (n == 11) set_in(1'b0, 1'b0, 16'd7, 16'd2, 1'b0);
      sample(1'b0, s_ds, s_bw, s_busy, s_done);
      if (n == 8) hold_ds = s_ds;
      if (s_done) begin
        done_n++;
        if (first_at == 0) begin first_at = n; first_ds = s_ds; end
        else begin second_at = n; second_ds = s_ds; end
      end
    end
    check("overlap_first_at",  first_at, 32'd5);
    check("overlap_first_ds",  {16'd0, first_ds}, 32'd6);
    check("overlap_hold_ds",   {16'd0, hold_ds}, 32'd6);
    check("overlap_second_at", second_at, 32'd11);
    check("overlap_second_ds", {16'd0, second_ds}, 32'd5);
    check("overlap_pulses",    done_n, 32'd2);

    // Reset two cycles into an operation.
    set_in(1'b0, 1'b1, 16'd9, 16'd3, 1'b0);
    @(posedge clk);
    @(negedge clk);
    set_in(1'b0, 1'b0, 16'd9, 16'd3, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_ds",      {28'd0, bus4.ds}, 32'd0);
    check("midrst_dborrow", {31'd0, bus4.dborrow}, 32'd0);
    check("midrst_busy",    {31'd0, bus4.busy}, 32'd0);
    done_n = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (bus4.done) done_n++;
    end
    check("midrst_no_done", done_n, 32'd0);
    rst = 1'b0;
    run_op(1'b0, 16'd5, 16'd2, 1'b1, r_ds, r_bw, done_at, busy_n, done_n);
    check("post_rst_ds",      {16'd0, r_ds}, 32'd2);
    check("post_rst_borrow",  {31'd0, r_bw}, 32'd0);
    check("post_rst_done_at", done_at, 32'd5);

    // Random sweep at both widths against plain integer arithmetic.
    for (int s = 0; s < 2; s++) begin
      int w;
      w = (s == 0) ? 4 : 8;
      for (int i = 0; i < 200; i++) begin
        int a, b, bin, diff, exp_v;
        a   = int'($urandom_range(0, (1 << w) - 1));
        b   = int'($urandom_range(0, (1 << w) - 1));
        bin = int'($urandom_range(0, 1));
        diff  = a - b - bin;
        exp_v = diff & ((1 << (w + 1)) - 1);
        run_op(s[0], 16'(a), 16'(b), bin[0], r_ds, r_bw, done_at, busy_n, done_n);
        check($sformatf("rand_w%0d_%0d_result", w, i),
              (32'(r_bw) << w) | 32'(r_ds), 32'(exp_v));
        check($sformatf("rand_w%0d_%0d_done_at", w, i), done_at, 32'(w + 1));
      end
    end

    check("busy_done_exclusive", both_cnt, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/serial_sub_borrow.md
Name: serial_sub_borrow

Overview:
- Multi-cycle, bit-serial subtractor with borrow-in and borrow-out. It is the inverse-direction companion of the team's combinational nibble adder.
- Computes ds = da - db - dbin, one bit per clock, LSB first.
- Start/busy/done handshake, so it can sit behind a control FSM that issues operations and collects results.
- Result and borrow are registered and held until the next completion.

Parameters:
- WIDTH, 4, operand and result width in bits (legal range 2..16).
- CW, $clog2(WIDTH+1), bit-counter width (derived, not overridden).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high; all state cleared immediately on assertion.
- start  input  1  request; sampled only in IDLE.
- da  input  WIDTH  minuend; sampled with start.
- db  input  WIDTH  subtrahend; sampled with start.
- dbin  input  1  borrow-in; sampled with start.
- ds  output  WIDTH  difference (registered).
- dborrow  output  1  borrow-out; 1 when da < db + dbin.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset values: ds=0, dborrow=0, busy=0, done=0, state=IDLE, counter=0, internal shift registers=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge k latches da into ra, db into rb, dbin into br; counter=0.
  - The same edge moves to SHIFT with busy=1.
- SHIFT (one bit per edge):
  - d = ra[0] ^ rb[0] ^ br.
  - br_next = (~ra[0] & rb[0]) | (~ra[0] & br) | (rb[0] & br).
  - ra and rb shift right; d is shifted into the MSB of result register rr; counter increments.
  - At the edge where counter reaches WIDTH-1 (i.e. bit WIDTH-1 processed, edge k+WIDTH):
    - the final rr is loaded into ds and br_next into dborrow;
    - the FSM moves to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Latency: start sampled at edge k; ds/dborrow valid and done=1 after edge k+WIDTH; done falls after edge k+WIDTH+1.
- Throughput: a start sampled in the DONE cycle is ignored. The next start can be accepted WIDTH+2 edges after the previous one.
- Arithmetic: {dborrow, ds} equals (da - db - dbin) mod 2^(WIDTH+1), with dborrow=1 exactly when the true difference is negative.
- start while busy=1 or in DONE: ignored. Operand changes after the sampling edge have no effect.
- Output hold: ds and dborrow change only at a completion edge or on reset. They hold the last result indefinitely while idle.
- Reset mid-operation: aborts immediately, all outputs return to reset values, no done pulse. start sampled at the first edge after rst deasserts is honoured.
- busy and done are never simultaneously 1.
- No X propagation: all registers are reset.

Decomposition:
- Shared package sub_pkg:
  - state enum {IDLE, SHIFT, DONE}, 2 bits;
  - default WIDTH constant.
- One natural sub-module, full_sub_bit: a combinational 1-bit full subtractor (a, b, bin -> d, bout), instantiated once inside the serial datapath.
- FSM, counter and shift registers live in serial_sub_borrow.

Test Plan:
- Basic subtraction: da=9, db=3, dbin=0, start for one cycle -> done pulse 4 cycles after the start edge, ds=0110, dborrow=0, busy high for exactly 4 cycles.
- Negative result: da=3, db=9, dbin=0 -> ds=1010, dborrow=1. Then da=0, db=0, dbin=1 -> ds=1111, dborrow=1.
- Boundary: da=15, db=15, dbin=1 -> ds=1111, dborrow=1. da=15, db=0, dbin=0 -> ds=1111, dborrow=0.
- Overlapping requests: start held high continuously with operands changed mid-operation -> only operands sampled in IDLE are used. The second result appears WIDTH+2 cycles after the first start. ds holds its value between completions.
- Reset mid-operation: assert rst 2 cycles after start -> outputs go to 0 immediately with no done pulse. A new start after deassert (da=5, db=2, dbin=1) -> ds=0010, dborrow=0.
- Random sweep: 200 random operand sets, compared against the reference model (da - db - dbin) mod 32, also at WIDTH=8 -> zero mismatches.
